// File: rtl/axis_fifo_reader.sv
// axis_fifo_reader
//   Drains a first-word-fall-through FIFO and replays its words as one
//   AXI4-Stream master burst of `len` beats per start pulse. A two-entry
//   buffer (output register + skid register) decouples m_axis_tready from
//   fifo_rd_en, so no combinational path runs from tready to the FIFO.
//
// Optional feature (define AXIS_FIFO_READER_STATS_EN):
//   stall_bp_cnt / stall_starve_cnt saturating stall counters, cleared on
//   start acceptance.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, len           burst request pulse and beat count (IDLE only)
//   abort                terminate burst, drop buffered beats
//   busy, done           burst in progress / one-cycle completion pulse
//   fifo_dout/empty      FWFT FIFO head word and empty flag
//   fifo_rd_en           pop FIFO head this cycle
//   m_axis_*             AXI4-Stream master (tkeep constant all ones)
//   stall_bp_cnt         [stats] cycles with tvalid && !tready
//   stall_starve_cnt     [stats] STREAM cycles starved by an empty FIFO
module axis_fifo_reader #(
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 16,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep
`ifdef AXIS_FIFO_READER_STATS_EN
    ,
    output logic [LEN_WIDTH-1:0]  stall_bp_cnt,
    output logic [LEN_WIDTH-1:0]  stall_starve_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  pop_cnt;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;
    logic                  skid_last;

    logic                  handshake;
    logic                  more_to_pop;
    logic                  pop_is_last;
    logic                  out_is_last;

    assign handshake   = m_axis_tvalid && m_axis_tready;
    assign more_to_pop = pop_cnt < len_q;
    assign pop_is_last = pop_cnt == len_q - LEN_WIDTH'(1);
    assign out_is_last = out_cnt == len_q - LEN_WIDTH'(1);

    // Pop only from registered state: a full skid register means both
    // buffer slots are occupied, so tready never reaches the FIFO directly.
    assign fifo_rd_en = (state == STREAM) && !fifo_empty && !skid_valid
                        && more_to_pop && !abort;

    assign m_axis_tkeep = '1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            len_q         <= '0;
            pop_cnt       <= '0;
            out_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            skid_data     <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q   <= len;
                            pop_cnt <= '0;
                            out_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= STREAM;
                        end else begin
                            // Zero-length burst: complete with no beats.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                STREAM: begin
                    if (abort) begin
                        // Abort wins over a simultaneous handshake; buffered
                        // words are dropped.
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        skid_valid    <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        if (fifo_rd_en) pop_cnt <= pop_cnt + LEN_WIDTH'(1);
                        if (handshake)  out_cnt <= out_cnt + LEN_WIDTH'(1);

                        if (handshake || !m_axis_tvalid) begin
                            // Output register is free: refill from skid
                            // first to keep order, else from the FIFO.
                            if (skid_valid) begin
                                m_axis_tdata  <= skid_data;
                                m_axis_tlast  <= skid_last;
                                m_axis_tvalid <= 1'b1;
                                skid_valid    <= 1'b0;
                            end else if (fifo_rd_en) begin
                                m_axis_tdata  <= fifo_dout;
                                m_axis_tlast  <= pop_is_last;
                                m_axis_tvalid <= 1'b1;
                            end else begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                            end
                        end else if (fifo_rd_en) begin
                            // Output stalled: park the popped word.
                            skid_data  <= fifo_dout;
                            skid_last  <= pop_is_last;
                            skid_valid <= 1'b1;
                        end

                        if (handshake && out_is_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_FIFO_READER_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_bp_cnt     <= '0;
            stall_starve_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_bp_cnt     <= '0;
            stall_starve_cnt <= '0;
        end else begin
            if (m_axis_tvalid && !m_axis_tready && stall_bp_cnt != '1)
                stall_bp_cnt <= stall_bp_cnt + LEN_WIDTH'(1);
            if (state == STREAM && fifo_empty && more_to_pop && stall_starve_cnt != '1)
                stall_starve_cnt <= stall_starve_cnt + LEN_WIDTH'(1);
        end
    end
`endif

endmodule
